// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : In-order instruction fetch with credit-limited prefetch FIFO and
//            redirect flush. Optional counters enabled by FETCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus8,
    output logic [1:0]  op,
    output logic [3:0]  cond,
    output logic [5:0]  funct,
    output logic [3:0]  rd
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flushed_instrs
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_SUM_W = c_CNT_W + 2;

    logic               r_run;
    logic [31:0]        r_fetch_pc;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_discard;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_aq_wr;
    logic [c_PTR_W-1:0] r_aq_rd;
    logic [31:0]        r_data_mem [DEPTH];
    logic [31:0]        r_pc_mem   [DEPTH];
    logic [31:0]        r_addr_q   [DEPTH];

    logic [c_SUM_W-1:0] w_used;
    logic               w_grant;
    logic               w_discarding;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_redirect_discard;
    logic               w_unused_bt;

    // Every slot is reserved from request until the head is consumed or the
    // stale response is discarded, so the FIFO can never overflow.
    assign w_used       = c_SUM_W'(r_count) + c_SUM_W'(r_outstanding) + c_SUM_W'(r_discard);
    assign imem_req     = r_run && (w_used < c_SUM_W'(DEPTH)) && !pc_src;
    assign imem_addr    = r_fetch_pc;
    assign w_grant      = imem_req && imem_gnt;
    assign w_discarding = (r_discard != '0);
    assign w_push       = imem_rvalid && !w_discarding && !pc_src;
    assign w_drop       = imem_rvalid && w_discarding && !pc_src;
    assign w_pop        = instr_valid && instr_ready;
    assign w_redirect_discard = r_discard + r_outstanding - c_CNT_W'(imem_rvalid);
    assign w_unused_bt  = ^branch_target[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_run         <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_aq_wr       <= '0;
            r_aq_rd       <= '0;
        end else if (pc_src) begin
            r_run         <= 1'b1;
            r_fetch_pc    <= {branch_target[31:2], 2'b00};
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= w_redirect_discard;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_aq_wr       <= '0;
            r_aq_rd       <= '0;
        end else begin
            r_run         <= 1'b1;
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_aq_wr    <= r_aq_wr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_aq_rd  <= r_aq_rd + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_outstanding <= r_outstanding + c_CNT_W'(w_grant) - c_CNT_W'(w_push);
            r_discard     <= r_discard - c_CNT_W'(w_drop);
            r_count       <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // Storage carries no reset; occupancy alone qualifies the contents.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_addr_q[r_aq_wr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= imem_rdata;
            r_pc_mem[r_wr_ptr]   <= r_addr_q[r_aq_rd];
        end
    end

    assign instr_valid = (r_count != '0);
    assign instr       = r_data_mem[r_rd_ptr];
    assign instr_pc    = r_pc_mem[r_rd_ptr];
    assign pc_plus8    = instr_pc + 32'd8;
    assign op          = instr[27:26];
    assign cond        = instr[31:28];
    assign funct       = instr[25:20];
    assign rd          = instr[15:12];

`ifdef FETCH_PERF_CNT_EN
    logic [c_CNT_W-1:0] w_flush_n;
    logic [32:0]        w_flush_sum;

    always_comb begin
        w_flush_n = '0;
        if (pc_src) begin
            w_flush_n = r_count;
        end
        if (imem_rvalid && (pc_src || w_discarding)) begin
            w_flush_n = w_flush_n + c_CNT_W'(1);
        end
        w_flush_sum = {1'b0, flushed_instrs} + 33'(w_flush_n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles   <= '0;
            flushed_instrs <= '0;
        end else begin
            if (instr_ready && !instr_valid && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            flushed_instrs <= w_flush_sum[32] ? '1 : w_flush_sum[31:0];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Scoreboard bench for instr_fetch with an in-order memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        pc_src = 1'b0;
    logic [31:0] branch_target = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus8;
    logic [1:0]  op;
    logic [3:0]  cond;
    logic [5:0]  funct;
    logic [3:0]  rd;

    instr_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_src(pc_src), .branch_target(branch_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .pc_plus8(pc_plus8),
        .op(op), .cond(cond), .funct(funct), .rd(rd)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit stale; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

    pend_t       mem_pend[$];
    exp_t        sb[$];
    logic [31:0] g_log[$];
    logic [31:0] p_log[$];
    logic [31:0] m_pc = '0;
    int          errors = 0;
    int          checks = 0;
    int          grant_cnt = 0;
    int          pops = 0;
    bit          rsp_en = 1'b1;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h9E37_79B9;
    endfunction

    // Memory: answers granted requests in order, earliest the cycle after grant.
    always @(posedge clk) begin
        pend_t q;
        exp_t  e;
        #1;
        if (reset) begin
            mem_pend.delete();
            imem_rvalid = 1'b0;
        end else if (rsp_en && mem_pend.size() > 0) begin
            q = mem_pend.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data(q.addr);
            if (!q.stale) begin
                e.pc = q.addr;
                e.data = mem_data(q.addr);
                sb.push_back(e);
            end
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
    end

    // Monitor: compares pops against the scoreboard and tracks grants/redirects.
    always @(negedge clk) begin
        exp_t  e;
        pend_t p;
        #1;
        if (!reset) begin
            if (instr_valid && instr_ready) begin
                pops++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: got pc=%h, expected no instruction", instr_pc);
                end else begin
                    e = sb.pop_front();
                    p_log.push_back(instr_pc);
                    if ({instr_pc, instr} !== {e.pc, e.data}) begin
                        errors++;
                        $display("FAIL pop_word: got pc=%h instr=%h, expected pc=%h instr=%h",
                                 instr_pc, instr, e.pc, e.data);
                    end
                    checks++;
                    if ({pc_plus8, op, cond, funct, rd} !==
                        {e.pc + 32'd8, e.data[27:26], e.data[31:28], e.data[25:20], e.data[15:12]}) begin
                        errors++;
                        $display("FAIL pop_fields: got pc8=%h op=%h cond=%h funct=%h rd=%h, expected pc8=%h instr=%h",
                                 pc_plus8, op, cond, funct, rd, e.pc + 32'd8, e.data);
                    end
                end
            end
            if (imem_req && imem_gnt) begin
                checks++;
                if (imem_addr !== m_pc) begin
                    errors++;
                    $display("FAIL grant_addr: got %h, expected %h", imem_addr, m_pc);
                end
                p.addr = m_pc;
                p.stale = 1'b0;
                mem_pend.push_back(p);
                g_log.push_back(m_pc);
                grant_cnt++;
                m_pc = m_pc + 32'd4;
            end
            if (pc_src) begin
                sb.delete();
                foreach (mem_pend[i]) mem_pend[i].stale = 1'b1;
                m_pc = {branch_target[31:2], 2'b00};
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; pc_src = 1'b0; instr_ready = 1'b1; imem_gnt = 1'b1;
        rsp_en = 1'b1; branch_target = '0;
        repeat (3) @(negedge clk);
        sb.delete(); g_log.delete(); p_log.delete();
        grant_cnt = 0; m_pc = 32'h0;
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!instr_valid && n < budget) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (!instr_valid) begin
            errors++;
            $display("FAIL %s_timeout: got no instr_valid in %0d cycles, expected valid", name, budget);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        @(negedge clk);
        reset = 1'b1; pc_src = 1'b0; instr_ready = 1'b1; imem_gnt = 1'b1; rsp_en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({imem_req, instr_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: got req=%b valid=%b, expected 0 0", imem_req, instr_valid);
        end
        @(negedge clk);
        sb.delete(); g_log.delete(); p_log.delete(); grant_cnt = 0; m_pc = 32'h0;
        reset = 1'b0;
        while (!instr_valid && n < 20) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL first_valid_cycle: got %0d, expected 3", n);
        end
        checks++;
        if ({instr_pc, pc_plus8} !== {32'h0, 32'h8}) begin
            errors++;
            $display("FAIL first_pc: got pc=%h pc8=%h, expected 0 8", instr_pc, pc_plus8);
        end
        repeat (12) @(negedge clk);
        #1;
        checks++;
        if (g_log.size() < 4 || {g_log[0], g_log[1], g_log[2], g_log[3]} !==
                                {32'h0, 32'h4, 32'h8, 32'hC}) begin
            errors++;
            $display("FAIL addr_seq: got %0d grants, expected 0,4,8,C", g_log.size());
        end
        checks++;
        if (p_log.size() < 3 || {p_log[0], p_log[1], p_log[2]} !== {32'h0, 32'h4, 32'h8}) begin
            errors++;
            $display("FAIL pc_seq: got %0d pops, expected pcs 0,4,8", p_log.size());
        end
    endtask

    task automatic test_full();
        do_reset();
        instr_ready = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        checks++;
        if (grant_cnt !== 2) begin
            errors++;
            $display("FAIL full_grants: got %0d, expected 2", grant_cnt);
        end
        checks++;
        if ({imem_req, instr_valid} !== 2'b01) begin
            errors++;
            $display("FAIL full_state: got req=%b valid=%b, expected 0 1", imem_req, instr_valid);
        end
        @(negedge clk); instr_ready = 1'b1;
        @(negedge clk); instr_ready = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
            errors++;
            $display("FAIL full_refill: got req=%b addr=%h, expected 1 00000008", imem_req, imem_addr);
        end
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (grant_cnt !== 3 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL full_one_more: got grants=%0d req=%b, expected 3 0", grant_cnt, imem_req);
        end
        instr_ready = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_gnt_stall();
        do_reset();
        imem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
                errors++;
                $display("FAIL stall_hold: got req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
            end
        end
        @(negedge clk); imem_gnt = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (imem_addr !== 32'h4 || grant_cnt !== 1) begin
            errors++;
            $display("FAIL stall_release: got addr=%h grants=%0d, expected 00000004 1", imem_addr, grant_cnt);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_redirect();
        int n = 0;
        do_reset();
        rsp_en = 1'b0;
        while (grant_cnt < 2 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        pc_src = 1'b1; branch_target = 32'h0000_0103;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redirect_req: got %b, expected 0", imem_req);
        end
        @(negedge clk);
        pc_src = 1'b0;
        #1;
        checks++;
        if (imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL redirect_addr: got %h, expected 00000100", imem_addr);
        end
        rsp_en = 1'b1;
        wait_valid("redirect", 20);
        checks++;
        if (instr_pc !== 32'h100) begin
            errors++;
            $display("FAIL redirect_first_pc: got %h, expected 00000100", instr_pc);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_redirect_pop();
        int n = 0;
        do_reset();
        instr_ready = 1'b0; rsp_en = 1'b0;
        while (grant_cnt < 2 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        rsp_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        instr_ready = 1'b1; pc_src = 1'b1; branch_target = 32'h0000_0200;
        #1;
        checks++;
        if ({instr_valid, instr_pc} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL rp_head: got valid=%b pc=%h, expected 1 00000000", instr_valid, instr_pc);
        end
        @(negedge clk);
        pc_src = 1'b0;
        #1;
        checks++;
        if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
            errors++;
            $display("FAIL rp_after: got valid=%b req=%b addr=%h, expected 0 1 00000200",
                     instr_valid, imem_req, imem_addr);
        end
        wait_valid("rp", 20);
        checks++;
        if (instr_pc !== 32'h200) begin
            errors++;
            $display("FAIL rp_first_pc: got %h, expected 00000200", instr_pc);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_reset();
        repeat (3) @(negedge clk);
        pc_src = 1'b1; branch_target = 32'h0000_0300;
        @(negedge clk);
        branch_target = 32'h0000_0400;
        @(negedge clk);
        pc_src = 1'b0;
        #1;
        checks++;
        if (imem_addr !== 32'h400) begin
            errors++;
            $display("FAIL b2b_addr: got %h, expected 00000400", imem_addr);
        end
        wait_valid("b2b", 20);
        checks++;
        if (instr_pc !== 32'h400) begin
            errors++;
            $display("FAIL b2b_first_pc: got %h, expected 00000400", instr_pc);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_wrap();
        int n = 0;
        do_reset();
        @(negedge clk);
        pc_src = 1'b1; branch_target = 32'hFFFF_FFFE;
        @(negedge clk);
        pc_src = 1'b0;
        g_log.delete(); p_log.delete();
        while (p_log.size() < 2 && n < 40) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (g_log.size() < 2 || {g_log[0], g_log[1]} !== {32'hFFFF_FFFC, 32'h0}) begin
            errors++;
            $display("FAIL wrap_addr: got %0d grants, expected FFFFFFFC then 00000000", g_log.size());
        end
        checks++;
        if (p_log.size() < 2 || {p_log[0], p_log[1]} !== {32'hFFFF_FFFC, 32'h0}) begin
            errors++;
            $display("FAIL wrap_pc: got %0d pops, expected pcs FFFFFFFC then 00000000", p_log.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_stream();
        int start_pops;
        do_reset();
        start_pops = pops;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            imem_gnt      = ($urandom_range(0, 3) != 0);
            instr_ready   = ($urandom_range(0, 3) != 0);
            rsp_en        = ($urandom_range(0, 3) != 0);
            pc_src        = ($urandom_range(0, 29) == 0);
            branch_target = $urandom;
        end
        @(negedge clk);
        pc_src = 1'b0; imem_gnt = 1'b0; rsp_en = 1'b1; instr_ready = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: got %0d expected words left valid=%b, expected 0 0",
                     sb.size(), instr_valid);
        end
        checks++;
        if (pops - start_pops < 40) begin
            errors++;
            $display("FAIL stream_throughput: got %0d pops, expected at least 40", pops - start_pops);
        end
        imem_gnt = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full();
        test_gnt_stall();
        test_redirect();
        test_redirect_pop();
        test_back_to_back();
        test_wrap();
        test_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the controller and decoder.
- Owns the fetch PC and issues in-order word reads to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small FIFO and presents one instruction per cycle with valid/ready, pre-split into the op/cond/funct/rd fields the controller consumes.
- Redirects on pc_src from the controller's condition logic, flushing queued and in-flight fetches.

Parameters:
DEPTH, 2, FIFO entries and maximum in-flight requests (power of two, >=2)
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
imem_req  output  1  fetch request
imem_addr  output  32  fetch word address, bits [1:0] always 0
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  read data valid, in order, one per granted request
imem_rdata  input  32  read data
pc_src  input  1  redirect strobe from controller
branch_target  input  32  redirect address
instr_valid  output  1  FIFO head valid
instr_ready  input  1  consumer accepts head
instr  output  32  head instruction word
instr_pc  output  32  address of head instruction
pc_plus8  output  32  instr_pc + 8, the ARM PC-read value
op  output  2  instr[27:26]
cond  output  4  instr[31:28]
funct  output  6  instr[25:20]
rd  output  4  instr[15:12]

Behaviour:
- Reset, synchronous, active-high, clk only: fetch_pc = RESET_PC; FIFO empty; outstanding = 0; discard = 0; imem_req = 0; instr_valid = 0.
  - Data outputs are don't-care while instr_valid = 0. Reset mid-transaction drops all state; later stray rvalid pulses are ignored only if discard covers them, so the memory must also be reset.
- Credit: credit = DEPTH - (occupancy + outstanding + discard).
  - imem_req = (credit > 0) && !pc_src. Combinational, registered sources only plus pc_src.
  - imem_addr = fetch_pc.
- Grant (imem_req && imem_gnt): fetch_pc += 4, wrap-around at 2^32 allowed; outstanding += 1. The address of each granted request is pushed into an address queue alongside data.
- Response (imem_rvalid):
  - If discard > 0: discard -= 1, data dropped.
  - Else: push {imem_rdata, addr} into FIFO; outstanding -= 1.
  - Earliest response is the cycle after grant. Response and new grant in the same cycle are both legal.
- Output: head presented when occupancy > 0. Pop when instr_valid && instr_ready.
  - Latency: grant at cycle N, rvalid at N+1 gives instr_valid at N+2 (FIFO registered).
- Full: credit = 0 means no request, so the FIFO can never overflow. A push and a pop in the same cycle keep occupancy unchanged.
- Redirect (pc_src = 1), highest priority:
  - fetch_pc <= {branch_target[31:2], 2'b00}.
  - FIFO flushed; a pop in the same cycle is still treated as consumed.
  - discard <= discard + outstanding - (rvalid this cycle ? 1 : 0); outstanding <= 0. An rvalid in the redirect cycle is dropped.
  - imem_req forced 0 that cycle; requests to the new target start next cycle if credit allows.
  - Back-to-back redirects: each overrides the previous.
- Field outputs are pure slices of instr.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs stall_cycles (32) and flushed_instrs (32), both reset to 0 and saturating at all-ones.
  - stall_cycles increments each cycle with instr_ready = 1 and instr_valid = 0.
  - flushed_instrs adds FIFO occupancy plus discarded responses at each redirect/discard event.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, gnt tied 1, rvalid one cycle after grant, ready = 1 -> imem_addr sequence 0,4,8,C; instr_valid first at cycle 3 after reset release; instr_pc 0,4,8; pc_plus8 8,C,10.
- ready = 0 with DEPTH = 2 -> exactly 2 grants, then imem_req = 0 with FIFO full; ready = 1 for one cycle -> one pop, one new request at addr 8.
- gnt = 0 for 5 cycles -> imem_req held 1, imem_addr held at 0, fetch_pc unchanged; gnt = 1 -> advances to 4.
- Two requests in flight, pc_src = 1 with branch_target = 32'h0000_0103 -> next imem_addr = 0x100; both stale responses dropped; first instr_valid carries instr_pc = 0x100.
- pc_src coincident with rvalid and a pop -> popped item consumed, arriving word dropped, discard = outstanding - 1, FIFO empty next cycle.
- fetch_pc = 32'hFFFF_FFFC, granted -> next imem_addr = 0; instr_pc for the wrapped fetch = 0.
